// File: rtl/uart_tx_fifo_if.sv
// Byte handshake between a producer and the UART transmitter's input FIFO.
interface uart_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter (LSB first, CLKS_PER_BIT clocks per bit) fed by a
// small byte FIFO; frames go out back-to-back with a one-cycle idle gap.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        tx_clk,
   input  logic                        tx_rst_n,
   input  logic                        tx_en,
   uart_tx_if.slave                    bus,
   output logic                        tx_out,
   output logic                        tx_busy,
   output logic                        tx_done,
   output logic [$clog2(FIFO_DEPTH):0] tx_level
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             ready_q;
   logic             full, empty, wr, pop;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             out_d, busy_d, done_d;

   assign full         = (tx_level == LVL_FULL);
   assign empty        = (tx_level == '0);
   assign bus.tx_ready = ready_q;
   // A pop in the same cycle frees the slot, so a write into a full FIFO is kept.
   assign wr = tx_en && bus.tx_valid && ready_q && (!full || pop);

   always_ff @(posedge tx_clk) begin
      if (wr) mem[wr_ptr] <= bus.tx_data;
   end

   always_ff @(posedge tx_clk or negedge tx_rst_n) begin
      if (!tx_rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         tx_level <= '0;
         ready_q  <= 1'b0;
      end else if (!tx_en) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         tx_level <= '0;
         ready_q  <= 1'b0;
      end else begin
         if (wr)  wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr, pop})
            2'b10:   tx_level <= tx_level + LVL_W'(1);
            2'b01:   tx_level <= tx_level - LVL_W'(1);
            default: tx_level <= tx_level;
         endcase
         ready_q <= !full;
      end
   end

   always_ff @(posedge tx_clk or negedge tx_rst_n) begin
      if (!tx_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         tx_out  <= 1'b1;
         tx_busy <= 1'b0;
         tx_done <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         tx_out  <= out_d;
         tx_busy <= busy_d;
         tx_done <= done_d;
      end
   end

   always_ff @(posedge tx_clk) begin
      shift_q <= shift_d;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      out_d   = tx_out;
      busy_d  = tx_busy;
      done_d  = 1'b0;
      pop     = 1'b0;
      if (!tx_en) begin
         state_d = IDLE;
         cnt_d   = '0;
         bit_d   = '0;
         out_d   = 1'b1;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               out_d  = 1'b1;
               busy_d = 1'b0;
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = mem[rd_ptr];
                  cnt_d   = '0;
                  out_d   = 1'b0;
                  busy_d  = 1'b1;
                  state_d = START;
               end
            end
            START: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  bit_d   = '0;
                  out_d   = shift_q[0];
                  state_d = DATA;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            DATA: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d = '0;
                  if (bit_q == 3'd7) begin
                     out_d   = 1'b1;
                     state_d = STOP;
                  end else begin
                     shift_d = shift_q >> 1;
                     out_d   = shift_q[1];
                     bit_d   = bit_q + 3'd1;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            STOP: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               out_d   = 1'b1;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

UART transmitter with a small input FIFO. It is the transmit stage feeding the serial line consumed by the team's UART receiver: 8N1 framing, LSB first, and the same 16-clocks-per-bit oversampling ratio the receiver uses. Bytes are accepted over a valid/ready handshake, buffered, and serialised back-to-back. A one-cycle idle gap separates consecutive frames.

## Interface
- CLKS_PER_BIT, 16, clock cycles per serial bit. Must equal the receiver's oversample count.
- FIFO_DEPTH, 4, input FIFO entries. Power of 2, ≥2.
- tx_clk  in  1  transmit clock; all logic on rising edge.
- tx_rst_n  in  1  reset, asynchronous assert, active-low.
- tx_en  in  1  block enable. Low flushes FIFO, aborts frame, holds line idle.
- tx_data  in  8  byte to send.
- tx_valid  in  1  tx_data valid this cycle.
- tx_ready  out  1  FIFO can accept; equals tx_en && !full, registered.
- tx_out  out  1  serial line, idle high.
- tx_busy  out  1  high while a frame (start..stop) is on the line.
- tx_done  out  1  one-cycle pulse when a stop bit completes.
- tx_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- Reset (tx_rst_n=0, any time, asynchronous) forces:
  - tx_out=1, tx_busy=0, tx_done=0, tx_level=0, tx_ready=0.
  - FIFO pointers 0, state IDLE, counters 0.
  - tx_ready rises on the first edge after release if tx_en=1.
- Push: tx_valid && tx_ready at a rising edge writes tx_data and increments tx_level. Writes while !tx_ready are dropped silently.
- Pop: the FSM reads the head entry when it leaves IDLE.
- Simultaneous push and pop leaves tx_level unchanged. The written byte is not lost.
- FSM states:
  - IDLE:
    - tx_out=1, tx_busy=0.
    - If tx_en && level>0: pop into shift register, clear bit counter, tx_out<=0, tx_busy<=1, go to START.
  - START:
    - Hold tx_out=0 for CLKS_PER_BIT cycles.
    - At count CLKS_PER_BIT-1: tx_out<=shift[0], bit index 0, go to DATA.
  - DATA:
    - Each bit is held CLKS_PER_BIT cycles.
    - At the end of bit 7: tx_out<=1, go to STOP.
    - Otherwise: shift right, tx_out<=next bit.
  - STOP:
    - Hold tx_out=1 for CLKS_PER_BIT cycles.
    - At the end: tx_done<=1 for one cycle, tx_busy<=0, go to IDLE.
  - Unused encodings go to IDLE with tx_out=1.
- tx_en=0, synchronous: on the next edge the FSM returns to IDLE.
  - tx_out=1, tx_busy=0, no tx_done.
  - FIFO flushed, tx_level=0, tx_ready=0.
  - A partial frame is truncated and never resumed.
- Width rules:
  - Cycle counter is $clog2(CLKS_PER_BIT) bits and wraps to 0 at CLKS_PER_BIT-1.
  - Bit index is 3 bits.
  - FIFO pointers wrap modulo FIFO_DEPTH; full/empty come from the occupancy count.

## Timing
- Push at edge N into an empty FIFO with FSM idle:
  - tx_level=1 after N.
  - Pop and start bit (tx_out=0) after edge N+1.
- Start bit spans edges N+1..N+1+CLKS_PER_BIT.
- Data bit i spans N+1+CLKS_PER_BIT*(i+1) for CLKS_PER_BIT cycles.
- Stop bit starts at N+1+9*CLKS_PER_BIT.
- Return to IDLE and tx_done pulse at N+1+10*CLKS_PER_BIT, i.e. 160 cycles after the start edge at default CLKS_PER_BIT.
- Back-to-back: the next start bit begins exactly one cycle after tx_done, so the idle high lasts one cycle.
- tx_ready deasserts the edge after the FIFO becomes full. It reasserts the edge after a pop frees an entry.
- tx_out changes only on bit boundaries; no glitches between them.

## Test plan
- Single byte: reset, push 0xA5 at edge N.
  - tx_out low for 16 cycles from N+1, then bits 1,0,1,0,0,1,0,1 each 16 cycles, then high 16 cycles.
  - tx_done pulses at N+161; tx_busy high from N+1 to N+160.
- Back-to-back: push 0x00, 0xFF, 0x3C on consecutive cycles.
  - Three frames decode correctly with exactly one idle-high cycle between them.
  - tx_level peaks at 2 (first byte pops immediately); three tx_done pulses, 161 cycles apart.
- FIFO full: hold tx_valid with bytes 0x11..0x16 while a frame is active.
  - tx_ready drops once 4 entries are queued, and excess bytes are dropped.
  - Frames sent: 0x11, 0x12, 0x13, 0x14, 0x15 (0x11 was in flight, plus 4 queued).
- Enable drop: clear tx_en during DATA bit 3.
  - Next edge: tx_out=1, tx_busy=0, tx_level=0, tx_ready=0, no tx_done.
  - After re-enable, a push of 0x5A is sent cleanly.
- Async reset mid-frame: pulse tx_rst_n low between clock edges during the START state.
  - All outputs take reset values immediately, without waiting for a clock edge.
  - After release, the next push transmits normally.
- Loopback: tx_out drives the receiver's rx_in, rx_start=1, rx_en=1; push 0x5A then 0xC3.
  - Receiver raises rx_done with rx_out=0x5A, then rx_out=0xC3.
  - rx_err never asserts.
